axis_replay_window: RTL and testbench

- AXI-Stream replay buffer with a bounded retry budget, for the MAC transmit path.
- Retains the first BUF_SIZE words of each packet so the consumer (collision/backoff logic) can restart the packet from word 0.
- Supersedes the fixed replay buffer. New features: synchronous reset, a MAX_REPLAYS limit with a replay counter, defined (non-fatal) handling of illegal replays, and a packet-release strobe.

---
 rtl/axis_replay_window.sv | 222 ++++++++++++++++++++++
 tb/tb_axis_replay_window.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_replay_window.sv
// AXI-Stream replay buffer for the MAC transmit path. The leading words of
// each packet are kept in a circular RAM so that the collision/backoff logic
// can restart the packet from word 0 a bounded number of times. Once a packet
// can no longer be replayed the RAM degrades into an ordinary streaming FIFO.
module axis_replay_window #(
    parameter int DATA_WIDTH  = 9,
    parameter int BUF_SIZE    = 54,
    parameter int MAX_REPLAYS = 15
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            s_axis_data,
    input  logic                             s_axis_valid,
    output logic                             s_axis_ready,
    input  logic                             s_axis_last,
    output logic [DATA_WIDTH-1:0]            m_axis_data,
    output logic                             m_axis_valid,
    input  logic                             m_axis_ready,
    output logic                             m_axis_last,
    input  logic                             replay,
    input  logic                             done,
    output logic                             replayable,
    output logic [$clog2(MAX_REPLAYS+1)-1:0] replay_count,
    output logic                             replay_err,
    output logic                             released
);

    localparam int AW    = $clog2(BUF_SIZE + 1);
    localparam int DEPTH = 2 ** AW;
    localparam int PW    = AW + 1;
    localparam int CW    = $clog2(MAX_REPLAYS + 1);
    localparam int HW    = $clog2(BUF_SIZE + 2);

    localparam logic [PW:0]   DEPTH_W  = (PW+1)'(DEPTH);
    localparam logic [HW-1:0] HS_FALL  = HW'(BUF_SIZE);
    localparam logic [HW-1:0] HS_SAT   = HW'(BUF_SIZE + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_REPLAYS);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_REPLAYS - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  in_valid_q, in_valid_d;
    logic                  in_last_q;
    logic [DATA_WIDTH-1:0] in_data_q;
    logic [PW-1:0]         s_ptr_q, s_ptr_d;
    logic [PW-1:0]         m_ptr_q, m_ptr_d;
    logic [PW-1:0]         last_ptr_q, last_ptr_d;
    logic                  last_valid_q, last_valid_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  replayable_q, replayable_d;
    logic [CW-1:0]         count_q, count_d;
    logic [HW-1:0]         hs_cnt_q, hs_cnt_d;
    logic                  last_hs_q, last_hs_d;
    logic                  err_q, err_d;
    logic                  released_q, released_d;
    logic                  run_q;

    logic          s_hs, m_hs, replay_ok, release_go, empty, load, last_seen;
    logic [PW-1:0] occ_raw;
    logic [PW:0]   fill_abs, fill_occ;

    // Fill levels include the word waiting in the input register, which is
    // always written to the RAM on the following edge.
    assign occ_raw  = s_ptr_q - m_ptr_q;
    assign fill_abs = {1'b0, s_ptr_q} + {{PW{1'b0}}, in_valid_q};
    assign fill_occ = {1'b0, occ_raw} + {{PW{1'b0}}, in_valid_q};

    // While replayable nothing may be overwritten, so writes stop at the
    // physical end of the RAM; afterwards only true occupancy matters.
    assign last_seen    = last_valid_q || (in_valid_q && in_last_q);
    assign s_axis_ready = run_q && !last_seen &&
                          (replayable_q ? (fill_abs < DEPTH_W) : (fill_occ < DEPTH_W));

    assign s_hs       = s_axis_valid && s_axis_ready;
    assign m_hs       = m_valid_q && m_axis_ready;
    assign replay_ok  = replay && replayable_q;
    assign release_go = last_hs_q && !replayable_q;
    assign empty      = (s_ptr_q == m_ptr_q);
    assign load       = !empty && (!m_valid_q || m_axis_ready) && !replay_ok && !release_go;

    assign m_axis_data  = m_data_q;
    assign m_axis_valid = m_valid_q;
    assign m_axis_last  = m_last_q;
    assign replayable   = replayable_q;
    assign replay_count = count_q;
    assign replay_err   = err_q;
    assign released     = released_q;

    // Next-state for pointers, output stage and replay bookkeeping.
    always_comb begin
        in_valid_d   = s_hs;
        s_ptr_d      = s_ptr_q;
        m_ptr_d      = m_ptr_q;
        last_ptr_d   = last_ptr_q;
        last_valid_d = last_valid_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        replayable_d = replayable_q;
        count_d      = count_q;
        hs_cnt_d     = hs_cnt_q;
        last_hs_d    = last_hs_q;
        err_d        = replay && !replayable_q;
        released_d   = release_go;

        if (in_valid_q) begin
            s_ptr_d = s_ptr_q + PW'(1);
            if (in_last_q) begin
                last_ptr_d   = s_ptr_q;
                last_valid_d = 1'b1;
            end
        end

        if (replay_ok) begin
            // Restart the pass; any un-accepted beat is withdrawn.
            m_ptr_d   = '0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            hs_cnt_d  = '0;
            last_hs_d = 1'b0;
            count_d   = (count_q == CNT_MAX) ? count_q : count_q + CW'(1);
            if (count_q >= CNT_LAST || done) begin
                replayable_d = 1'b0;
            end
        end else begin
            if (m_hs) begin
                if (hs_cnt_q != HS_SAT) begin
                    hs_cnt_d = hs_cnt_q + HW'(1);
                end
                if (m_last_q) begin
                    last_hs_d = 1'b1;
                end
                // Word BUF_SIZE leaving means word 0 may soon be overwritten.
                if (hs_cnt_q == HS_FALL) begin
                    replayable_d = 1'b0;
                end
            end
            if (done) begin
                replayable_d = 1'b0;
            end
            if (load) begin
                m_ptr_d   = m_ptr_q + PW'(1);
                m_valid_d = 1'b1;
                m_last_d  = last_valid_q && (m_ptr_q == last_ptr_q);
            end else if (m_hs) begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
            if (release_go) begin
                s_ptr_d      = '0;
                m_ptr_d      = '0;
                last_ptr_d   = '0;
                last_valid_d = 1'b0;
                m_valid_d    = 1'b0;
                m_last_d     = 1'b0;
                replayable_d = 1'b1;
                count_d      = '0;
                hs_cnt_d     = '0;
                last_hs_d    = 1'b0;
            end
        end
    end

    // Control state with synchronous reset; run_q keeps the slave idle during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q        <= 1'b0;
            in_valid_q   <= 1'b0;
            s_ptr_q      <= '0;
            m_ptr_q      <= '0;
            last_ptr_q   <= '0;
            last_valid_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            replayable_q <= 1'b1;
            count_q      <= '0;
            hs_cnt_q     <= '0;
            last_hs_q    <= 1'b0;
            err_q        <= 1'b0;
            released_q   <= 1'b0;
        end else begin
            run_q        <= 1'b1;
            in_valid_q   <= in_valid_d;
            s_ptr_q      <= s_ptr_d;
            m_ptr_q      <= m_ptr_d;
            last_ptr_q   <= last_ptr_d;
            last_valid_q <= last_valid_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            replayable_q <= replayable_d;
            count_q      <= count_d;
            hs_cnt_q     <= hs_cnt_d;
            last_hs_q    <= last_hs_d;
            err_q        <= err_d;
            released_q   <= released_d;
        end
    end

    // Input pipeline stage; contents only matter while in_valid_q is set.
    always_ff @(posedge clk) begin
        if (s_hs) begin
            in_data_q <= s_axis_data;
            in_last_q <= s_axis_last;
        end
    end

    // RAM write port, fed from the input stage.
    always_ff @(posedge clk) begin
        if (!rst && in_valid_q) begin
            mem_q[s_ptr_q[AW-1:0]] <= in_data_q;
        end
    end

    // RAM registered read straight into the output data register.
    always_ff @(posedge clk) begin
        if (load) begin
            m_data_q <= mem_q[m_ptr_q[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_axis_replay_window.sv
// Self-checking bench for axis_replay_window: directed packet scenarios with
// randomized data and handshakes, checked against a packet-level model.
module tb_axis_replay_window;

    localparam int DW = 9;
    localparam int BS = 54;
    localparam int MR = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_axis_data = '0;
    logic          s_axis_valid = 1'b0;
    logic          s_axis_ready;
    logic          s_axis_last = 1'b0;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready = 1'b0;
    logic          m_axis_last;
    logic          replay = 1'b0;
    logic          done = 1'b0;
    logic          replayable;
    logic [1:0]    replay_count;
    logic          replay_err;
    logic          released;

    int n_checks = 0;
    int n_fail   = 0;
    int rel_cnt  = 0;

    // Reference model: expected packet contents and replay state.
    logic [DW-1:0] pkt [0:3][0:127];
    int cur_p     = 0;
    int pkt_len   = 0;
    int exp_idx   = 0;
    int exp_count = 0;
    bit exp_rp    = 1'b1;

    axis_replay_window #(
        .DATA_WIDTH (DW),
        .BUF_SIZE   (BS),
        .MAX_REPLAYS(MR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis_data (s_axis_data),
        .s_axis_valid(s_axis_valid),
        .s_axis_ready(s_axis_ready),
        .s_axis_last (s_axis_last),
        .m_axis_data (m_axis_data),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready),
        .m_axis_last (m_axis_last),
        .replay      (replay),
        .done        (done),
        .replayable  (replayable),
        .replay_count(replay_count),
        .replay_err  (replay_err),
        .released    (released)
    );

    always #5 clk = ~clk;

    // Count release pulses over the whole run.
    always @(negedge clk) begin
        if (released === 1'b1) rel_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int p, input int len, input bit rnd);
        for (int i = 0; i < len; i++) pkt[p][i] = rnd ? DW'($urandom) : DW'(i);
    endtask

    task automatic send(input int p, input int len, input bit mark_last, input int pct);
        int i = 0;
        int budget = 0;
        while (i < len && budget < 4000) begin
            s_axis_valid = ($urandom_range(99) < pct);
            s_axis_data  = pkt[p][i];
            s_axis_last  = mark_last && (i == len - 1);
            if (s_axis_valid && s_axis_ready) i++;
            tick();
            budget++;
        end
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
        chk("send_complete", i, len);
    endtask

    task automatic recv(input int n, input int pct);
        int got = 0;
        int budget = 0;
        bit stall = 1'b0;
        logic [DW-1:0] pd = '0;
        logic pl = 1'b0;
        while (got < n && budget < 4000) begin
            if (stall) begin
                chk("hold_valid", m_axis_valid, 1);
                chk("hold_data", m_axis_data, pd);
                chk("hold_last", m_axis_last, pl);
            end
            m_axis_ready = ($urandom_range(99) < pct);
            if (m_axis_valid && m_axis_ready) begin
                chk("data", m_axis_data, pkt[cur_p][exp_idx & 127]);
                chk("last", m_axis_last, (exp_idx == pkt_len - 1));
                exp_idx++;
                got++;
            end
            stall = m_axis_valid && !m_axis_ready;
            pd    = m_axis_data;
            pl    = m_axis_last;
            tick();
            budget++;
        end
        m_axis_ready = 1'b0;
        chk("recv_complete", got, n);
        // The (BS+1)th handshake of a pass closes the replay window.
        if (exp_idx > BS) exp_rp = 1'b0;
    endtask

    task automatic replay_step();
        bit honoured = exp_rp;
        replay = 1'b1;
        tick();
        replay = 1'b0;
        if (honoured) begin
            exp_idx = 0;
            exp_count++;
            if (exp_count >= MR) exp_rp = 1'b0;
            chk("replay_count", replay_count, exp_count);
            chk("replay_withdraw", m_axis_valid, 0);
            chk("replay_no_err", replay_err, 0);
        end else begin
            chk("replay_err", replay_err, 1);
            chk("replay_count_hold", replay_count, exp_count);
            tick();
            chk("replay_err_pulse", replay_err, 0);
        end
        chk("replayable", replayable, exp_rp);
    endtask

    task automatic done_step();
        done = 1'b1;
        tick();
        done = 1'b0;
        exp_rp = 1'b0;
        chk("done_replayable", replayable, 0);
    endtask

    task automatic release_step();
        chk("rel_not_yet", released, 0);
        tick();
        chk("released", released, 1);
        chk("rel_s_ready", s_axis_ready, 1);
        chk("rel_count", replay_count, 0);
        chk("rel_replayable", replayable, 1);
        tick();
        chk("rel_pulse_end", released, 0);
        exp_count = 0;
        exp_rp    = 1'b1;
        exp_idx   = 0;
    endtask

    initial begin
        // Reset state, held while rst is high.
        tick();
        tick();
        chk("rst_s_ready", s_axis_ready, 0);
        chk("rst_m_valid", m_axis_valid, 0);
        chk("rst_m_last", m_axis_last, 0);
        chk("rst_replayable", replayable, 1);
        chk("rst_count", replay_count, 0);
        chk("rst_err", replay_err, 0);
        chk("rst_released", released, 0);
        rst = 1'b0;
        chk("rst_ready_before_edge", s_axis_ready, 0);
        tick();
        chk("rst_ready_after_edge", s_axis_ready, 1);

        // 10-word packet, replayed once after its last handshake, then done.
        fill(0, 10, 1'b0);
        cur_p = 0; pkt_len = 10; exp_idx = 0;
        fork
            send(0, 10, 1'b1, 100);
            recv(10, 100);
        join
        chk("short_still_replayable", replayable, exp_rp);
        replay_step();
        recv(10, 100);
        done_step();
        release_step();

        // 100-word packet, window closes after handshake 55, late replay is an error.
        fill(1, 100, 1'b1);
        cur_p = 1; pkt_len = 100; exp_idx = 0;
        fork
            send(1, 100, 1'b1, 100);
            begin
                recv(54, 100);
                chk("window_open_54", replayable, exp_rp);
                recv(1, 100);
                chk("window_closed_55", replayable, exp_rp);
                replay_step();
                recv(45, 100);
            end
        join
        release_step();

        // 100-word packet, replay after handshake 20, then full delivery.
        fill(1, 100, 1'b1);
        cur_p = 1; pkt_len = 100; exp_idx = 0;
        fork
            send(1, 100, 1'b1, 100);
            begin
                int w = 0;
                recv(20, 100);
                replay_step();
                while (!m_axis_valid && w < 3) begin
                    tick();
                    w++;
                end
                chk("replay_word0_latency_ok", (w <= 2), 1);
                recv(100, 100);
            end
        join
        release_step();

        // 5-word packet, replay budget exhausted, then an illegal replay.
        fill(2, 5, 1'b1);
        cur_p = 2; pkt_len = 5; exp_idx = 0;
        fork
            send(2, 5, 1'b1, 100);
            recv(5, 100);
        join
        replay_step();
        recv(3, 100);
        replay_step();
        replay_step();
        replay_step();
        recv(5, 100);
        release_step();

        // Three back-to-back 60-word packets with random handshakes.
        for (int p = 0; p < 3; p++) fill(p, 60, 1'b1);
        fork
            for (int p = 0; p < 3; p++) send(p, 60, 1'b1, 50);
            for (int p = 0; p < 3; p++) begin
                cur_p = p; pkt_len = 60; exp_idx = 0;
                recv(60, 50);
                release_step();
            end
        join

        // Reset in the middle of a 60-word packet, then a clean 8-word packet.
        fill(3, 60, 1'b1);
        cur_p = 3; pkt_len = 60; exp_idx = 0;
        fork
            send(3, 30, 1'b0, 100);
            recv(20, 100);
        join
        rst = 1'b1;
        tick();
        tick();
        chk("midrst_s_ready", s_axis_ready, 0);
        chk("midrst_m_valid", m_axis_valid, 0);
        chk("midrst_m_last", m_axis_last, 0);
        chk("midrst_replayable", replayable, 1);
        chk("midrst_count", replay_count, 0);
        chk("midrst_released", released, 0);
        rst = 1'b0;
        tick();
        chk("midrst_ready_after", s_axis_ready, 1);
        chk("midrst_no_leftover", m_axis_valid, 0);
        exp_count = 0; exp_rp = 1'b1;
        fill(3, 8, 1'b1);
        cur_p = 3; pkt_len = 8; exp_idx = 0;
        fork
            send(3, 8, 1'b1, 100);
            recv(8, 100);
        join
        chk("post_rst_count", replay_count, 0);
        done_step();
        release_step();

        chk("release_total", rel_cnt, 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
